// File: rtl/chs_power_scheduler.sv
// Channel power configuration scheduler: round-robin write arbitration with a
// power-budget check, plus a free-running channel scanner feeding the ModePower datapath.
module chs_power_scheduler #(
  parameter int unsigned SCAN_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_conf,
  input  logic [5:0]  budget,
  output logic [3:0]  grant,
  output logic        ack,
  output logic        nack,
  output logic [7:0]  chs_conf,
  output logic [1:0]  chs_sel,
  output logic        slot_start,
  output logic [5:0]  total_power,
  output logic        over_budget
);

  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned PW   = 6;
  localparam int unsigned HW   = 4;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cfg [N_CH];
  logic [1:0]      last_granted;
  logic [1:0]      cur_ch;
  logic [CW-1:0]   cur_conf;
  logic [1:0]      win_ch;
  logic            win_found;
  logic [PW-1:0]   new_total;
  logic            fits_budget;
  logic [3:0]      grant_nxt;
  logic            ack_nxt;
  logic            nack_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [1:0]      sel_nxt;

  function automatic logic [PW-1:0] contrib(input logic en, input logic [3:0] pwr);
    return en ? {2'b00, pwr} : '0;
  endfunction

  // Round-robin pick starting one past the last channel served.
  always_comb begin
    logic [1:0] idx;
    win_ch    = last_granted;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_granted + 2'(k);
      if (!win_found && req[idx]) begin
        win_ch    = idx;
        win_found = 1'b1;
      end
    end
  end

  // Total cannot underflow: the old contribution is always part of total_power.
  always_comb begin
    new_total   = total_power - contrib(cfg[cur_ch][7], cfg[cur_ch][3:0])
                              + contrib(cur_conf[7], cur_conf[3:0]);
    fits_budget = (new_total <= budget);
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = '0;
    ack_nxt   = 1'b0;
    nack_nxt  = 1'b0;
    case (state)
      IDLE:   if (win_found) state_nxt = CHECK;
      CHECK: begin
        grant_nxt = 4'b0001 << cur_ch;
        if (fits_budget) begin
          state_nxt = COMMIT;
          ack_nxt   = 1'b1;
        end else begin
          state_nxt = REJECT;
          nack_nxt  = 1'b1;
        end
      end
      COMMIT: state_nxt = IDLE;
      REJECT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      ack          <= 1'b0;
      nack         <= 1'b0;
      last_granted <= 2'd3;
      cur_ch       <= '0;
      cur_conf     <= '0;
      total_power  <= '0;
      over_budget  <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) cfg[i] <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      ack         <= ack_nxt;
      nack        <= nack_nxt;
      over_budget <= (total_power > budget);
      if (state == IDLE && win_found) begin
        cur_ch   <= win_ch;
        cur_conf <= req_conf[{win_ch, 3'b000} +: CW];
      end
      if (state == CHECK) begin
        last_granted <= cur_ch;
        if (fits_budget) begin
          cfg[cur_ch] <= cur_conf;
          total_power <= new_total;
        end
      end
    end
  end

  // Scanner: free-running, each channel presented for SCAN_HOLD cycles.
  always_comb begin
    hold_nxt = hold_cnt + HW'(1);
    sel_nxt  = chs_sel;
    if (hold_cnt >= HW'(SCAN_HOLD - 1)) begin
      hold_nxt = '0;
      sel_nxt  = chs_sel + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      chs_sel    <= '0;
      slot_start <= 1'b1;
      chs_conf   <= '0;
    end else begin
      hold_cnt   <= hold_nxt;
      chs_sel    <= sel_nxt;
      slot_start <= (hold_nxt == '0);
      chs_conf   <= cfg[sel_nxt];
    end
  end

endmodule

// File: tb/tb_chs_power_scheduler.sv
// Randomized and directed bench for chs_power_scheduler against a transaction-level model.
module tb_chs_power_scheduler;

  localparam int H0 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_conf;
  logic [5:0]  budget;

  logic [3:0]  grant, grant1;
  logic        ack, nack, ack1, nack1;
  logic [7:0]  chs_conf, chs_conf1;
  logic [1:0]  chs_sel, chs_sel1;
  logic        slot_start, slot_start1;
  logic [5:0]  total_power, total_power1;
  logic        over_budget, over_budget1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chs_power_scheduler #(.SCAN_HOLD(H0)) u0 (
    .clk(clk), .rst(rst), .req(req), .req_conf(req_conf), .budget(budget),
    .grant(grant), .ack(ack), .nack(nack), .chs_conf(chs_conf), .chs_sel(chs_sel),
    .slot_start(slot_start), .total_power(total_power), .over_budget(over_budget));

  chs_power_scheduler #(.SCAN_HOLD(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .req_conf(req_conf), .budget(budget),
    .grant(grant1), .ack(ack1), .nack(nack1), .chs_conf(chs_conf1), .chs_sel(chs_sel1),
    .slot_start(slot_start1), .total_power(total_power1), .over_budget(over_budget1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         k;           // active edges since reset release
  logic [7:0] m_cfg [4];
  int         phase;       // 0 waiting, 1 deciding, 2 result shown
  int         m_ch;
  logic [7:0] m_conf;
  int         last;
  logic [3:0] e_grant;
  logic       e_ack, e_nack, e_ob;
  logic [7:0] e_conf0, e_conf1;

  function automatic int contrib(input logic [7:0] c);
    return c[7] ? int'(c[3:0]) : 0;
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int i = 0; i < 4; i++) s += contrib(m_cfg[i]);
    return s;
  endfunction

  task automatic model_reset();
    k = 0; phase = 0; m_ch = 0; m_conf = 0; last = 3;
    for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
    e_grant = 0; e_ack = 0; e_nack = 0; e_ob = 0; e_conf0 = 0; e_conf1 = 0;
  endtask

  task automatic model_step();
    int pre, nt;
    pre = model_total();
    e_ob = (pre > int'(budget));
    e_conf0 = m_cfg[((k + 1) / H0) % 4];
    e_conf1 = m_cfg[(k + 1) % 4];
    k++;
    e_grant = 0; e_ack = 0; e_nack = 0;
    case (phase)
      0: if (req != 0) begin
        for (int j = 4; j >= 1; j--)
          if (req[(last + j) % 4]) m_ch = (last + j) % 4;
        m_conf = req_conf[8*m_ch +: 8];
        phase = 1;
      end
      1: begin
        nt = pre - contrib(m_cfg[m_ch]) + contrib(m_conf);
        if (nt <= int'(budget)) begin
          m_cfg[m_ch] = m_conf;
          e_ack = 1;
        end else e_nack = 1;
        e_grant = 4'(1 << m_ch);
        last = m_ch;
        phase = 2;
      end
      default: phase = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("grant", 32'(grant), 32'(e_grant));
    check("ack", 32'(ack), 32'(e_ack));
    check("nack", 32'(nack), 32'(e_nack));
    check("total_power", 32'(total_power), 32'(model_total()));
    check("over_budget", 32'(over_budget), 32'(e_ob));
    check("chs_sel", 32'(chs_sel), 32'((k / H0) % 4));
    check("slot_start", 32'(slot_start), 32'((k % H0) == 0));
    check("chs_conf", 32'(chs_conf), 32'(e_conf0));
    check("h1_grant", 32'(grant1), 32'(e_grant));
    check("h1_ack_nack", 32'({ack1, nack1}), 32'({e_ack, e_nack}));
    check("h1_total", 32'(total_power1), 32'(model_total()));
    check("h1_over", 32'(over_budget1), 32'(e_ob));
    check("h1_chs_sel", 32'(chs_sel1), 32'(k % 4));
    check("h1_slot_start", 32'(slot_start1), 32'(1));
    check("h1_chs_conf", 32'(chs_conf1), 32'(e_conf1));
  end

  // ---------------- directed helpers ----------------
  logic [3:0] g_q[$];
  int         t_q[$];
  logic       a_q[$];
  logic       n_q[$];

  task automatic txn(input logic [3:0] mask, input logic [31:0] conf, input logic [5:0] bud);
    g_q.delete(); t_q.delete(); a_q.delete(); n_q.delete();
    @(negedge clk); #1;
    req = mask; req_conf = conf; budget = bud;
    for (int c = 1; c <= 20 && req != 0; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        g_q.push_back(grant); t_q.push_back(c); a_q.push_back(ack); n_q.push_back(nack);
      end
      #1 req = req & ~grant;
    end
    check("txn_timeout", 32'(req), 32'(0));
    req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1; req = 0;
    @(negedge clk); #1 rst = 0;
  endtask

  logic [1:0] sel_hist [17];
  logic       ss_hist  [17];

  initial begin
    rst = 1; req = 0; req_conf = 0; budget = 0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_slot_start", 32'(slot_start), 32'(1));
    #1 rst = 0;

    // single commit: 0x8A under budget 20
    txn(4'b0001, 32'h0000_008A, 6'd20);
    check("s1_grant", 32'(g_q[0]), 32'h1);
    check("s1_latency", 32'(t_q[0]), 32'd2);
    check("s1_ack", 32'(a_q[0]), 32'd1);
    check("s1_total", 32'(total_power), 32'd10);

    // reject: 10 + 15 > 20
    txn(4'b0010, 32'h0000_CF00, 6'd20);
    check("s2_grant", 32'(g_q[0]), 32'h2);
    check("s2_nack", 32'({a_q[0], n_q[0]}), 32'b01);
    check("s2_total", 32'(total_power), 32'd10);

    // round-robin sweep from a fresh reset
    do_reset();
    txn(4'b1111, 32'h8181_8181, 6'd60);
    check("s3_count", 32'(g_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("s3_order", 32'(g_q[i]), 32'(1 << i));
      check("s3_time", 32'(t_q[i]), 32'(2 + 3 * i));
    end
    check("s3_total", 32'(total_power), 32'd4);

    // budget lowered under total, then disable write always passes
    do_reset();
    txn(4'b0001, 32'h0000_008A, 6'd20);
    @(negedge clk); #1 budget = 6'd5;
    @(negedge clk);
    check("s4_over", 32'(over_budget), 32'd1);
    check("s4_total_kept", 32'(total_power), 32'd10);
    txn(4'b0001, 32'h0000_0000, 6'd5);
    check("s4_ack", 32'(a_q[0]), 32'd1);
    repeat (2) @(negedge clk);
    check("s4_total", 32'(total_power), 32'd0);
    check("s4_over_clear", 32'(over_budget), 32'd0);

    // reset while the transaction is in CHECK
    @(negedge clk); #1 req = 4'b0001; req_conf = 32'h0000_008F; budget = 6'd60;
    @(negedge clk); #1 rst = 1; req = 0;
    @(negedge clk);
    check("s5_grant", 32'(grant), 32'd0);
    check("s5_outputs", 32'({ack, nack, total_power, over_budget, chs_conf, chs_sel}), 32'd0);
    #1 rst = 0;
    #1 check("s5_slot_start", 32'(slot_start), 32'd1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      sel_hist[n] = chs_sel; ss_hist[n] = slot_start;
    end
    check("s6_sel3", 32'(sel_hist[3]), 32'd0);
    check("s6_sel4", 32'(sel_hist[4]), 32'd1);
    check("s6_sel12", 32'(sel_hist[12]), 32'd3);
    check("s6_sel16", 32'(sel_hist[16]), 32'd0);
    check("s6_ss4", 32'(ss_hist[4]), 32'd1);
    check("s6_ss5", 32'(ss_hist[5]), 32'd0);
    check("s6_ss8", 32'(ss_hist[8]), 32'd1);
    check("s6_cfg_kept", 32'(total_power), 32'd0);

    // randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          req_conf[8*i +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(39) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(9) == 0) budget = 6'($urandom);
      if (cyc == 300) begin
        rst = 1; req = 0;
        @(negedge clk); #1 rst = 0;
      end
    end
    req = 0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chs_power_scheduler.md
CHS_POWER_SCHEDULER -- requirements
Module: chs_power_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_HOLD, default 4, giving the cycles each channel slot is presented on chs_conf (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester configuration write request, level, held until granted.
REQ-005 The block SHALL have port req_conf, input, 32 bits: the requested 8-bit config for requester i on req_conf[8i+7:8i].
REQ-006 The block SHALL have port budget, input, 6 bits: the total power budget, unsigned.
REQ-007 The block SHALL have port grant, output, 4 bits: one-hot, a 1-cycle pulse closing requester i's transaction.
REQ-008 The block SHALL have ports ack and nack, each output, 1 bit: a 1-cycle result pulse coincident with grant.
REQ-009 The block SHALL have port chs_conf, output, 8 bits: the config of the scanned channel, driving the ModePower datapath.
REQ-010 The block SHALL have port chs_sel, output, 2 bits: the scanned channel index.
REQ-011 The block SHALL have port slot_start, output, 1 bit: high in the first cycle of each scan slot.
REQ-012 The block SHALL have ports total_power (output, 6 bits, sum of enabled channel powers) and over_budget (output, 1 bit, registered total_power > budget).

Function
REQ-013 The config format SHALL be: bit7 enable, bit6 mode, bits5:4 reserved (stored unchanged), bits3:0 power.
REQ-014 A channel's contribution SHALL be power when enable=1, else 0; total_power SHALL be the 6-bit sum of four contributions (max 60, no overflow).
REQ-015 The FSM SHALL have states IDLE, CHECK, COMMIT and REJECT.
REQ-016 In IDLE, when req is nonzero, the block SHALL pick a winner round-robin starting at (last_granted+1) mod 4, latch its index and req_conf slice, and go to CHECK at the next edge.
REQ-017 In CHECK, the block SHALL compute new_total = total_power - old_contrib(ch) + new_contrib, sampling budget in this cycle only.
REQ-018 From CHECK, the FSM SHALL go to COMMIT when new_total <= budget, else to REJECT.
REQ-019 On the edge entering COMMIT, cfg[ch] and total_power SHALL update; COMMIT drives grant[ch]=1 and ack=1 for one cycle, then returns to IDLE.
REQ-020 REJECT SHALL drive grant[ch]=1 and nack=1 for one cycle, leave cfg and total unchanged, then return to IDLE.
REQ-021 last_granted SHALL update on both COMMIT and REJECT.
REQ-022 The request-to-grant latency SHALL be exactly 2 cycles, with one transaction per 3 cycles at most.
REQ-023 Writing enable=0 SHALL always pass the check, since the contribution only drops.
REQ-024 Lowering budget below total_power SHALL NOT alter any cfg, and over_budget SHALL assert one cycle later.
REQ-025 Requests that drop before grant SHALL be ignored if not yet latched; a latched transaction SHALL complete regardless.
REQ-026 The scanner SHALL hold chs_sel for SCAN_HOLD cycles, then advance mod 4 (3 wraps to 0), with slot_start high in each slot's first cycle; the scanner SHALL run independent of the FSM.
REQ-027 chs_conf SHALL equal cfg[chs_sel] registered, reflecting a commit to the scanned channel on the cycle after the commit edge.
REQ-028 Simultaneous COMMIT and a scanner slot change SHALL both take effect, with no stall.

Reset
REQ-029 When rst asserts, the block SHALL immediately force state=IDLE, all cfg=0, total_power=0, over_budget=0, last_granted=3 (channel 0 first), chs_sel=0, hold counter=0, grant/ack/nack=0, and chs_conf=0.
REQ-030 Reset asserted mid-transaction SHALL abort it without grant and without cfg write.
REQ-031 slot_start SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Scenario: budget=20, req[0] with conf=0x8A -> grant=0001 and ack 2 cycles later; total_power=10; chs_conf=0x8A during slot 0.
REQ-033 Scenario: then req[1] with conf=0xCF and budget=20 -> nack, grant=0010; total_power remains 10; cfg[1] remains 0x00.
REQ-034 Scenario: req=1111 held with all conf=0x81 and budget=60 -> grants in order 0001, 0010, 0100, 1000 at 3-cycle spacing; total_power=4.
REQ-035 Scenario: total=10, budget lowered to 5 -> over_budget=1 next cycle; a req[0] write of 0x00 -> ack; total=0 and over_budget=0.
REQ-036 Scenario: rst pulsed while in CHECK -> no grant; all outputs zero; chs_sel=0; slot_start=1 after release.
REQ-037 Scenario: SCAN_HOLD=4 -> chs_sel sequence 0,0,0,0,1,...,3,0, with slot_start every 4 cycles.
